// File: rtl/regfile_pkg.sv
// Shared parameters, constants and issue-stage address type for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_NUM_REGS = 32;
    localparam int unsigned DEF_NUM_RD   = 4;
    localparam int unsigned DEF_NUM_WR   = 2;
    localparam int unsigned DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

    // Width of a write-port index; never narrower than one bit.
    function automatic int unsigned port_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wr_select.sv
// Finds whether any enabled write port targets idx and which port wins (highest index).
module regfile_wr_select
    import regfile_pkg::*;
#(
    parameter  int unsigned NUM_WR = DEF_NUM_WR,
    parameter  int unsigned ADDR_W = DEF_ADDR_W,
    localparam int unsigned PORT_W = port_idx_w(NUM_WR)
) (
    input  logic [NUM_WR-1:0]        en,
    input  logic [NUM_WR*ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0]        idx,
    output logic                     hit_c,
    output logic [PORT_W-1:0]        port_c
);

    // Ascending scan: a later match overrides, so the highest port wins.
    always_comb begin
        hit_c  = 1'b0;
        port_c = '0;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (en[j] && (addr[j*ADDR_W +: ADDR_W] == idx)) begin
                hit_c  = 1'b1;
                port_c = PORT_W'(j);
            end
        end
    end

endmodule

// File: rtl/mp_register_file.sv
// N-read / M-write register file with per-register pending scoreboard; r0 is hardwired to zero.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data onto the read ports.
module mp_register_file
    import regfile_pkg::*;
#(
    parameter  int unsigned DATA_W   = DEF_DATA_W,
    parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter  int unsigned NUM_RD   = DEF_NUM_RD,
    parameter  int unsigned NUM_WR   = DEF_NUM_WR,
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_WR-1:0]        pend_set_en,
    input  logic [NUM_WR*ADDR_W-1:0] pend_set_addr
);

    localparam int unsigned PORT_W = port_idx_w(NUM_WR);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic [DATA_W-1:0]   wdata  [NUM_WR];
    logic [NUM_REGS-1:1] wr_hit;
    logic [PORT_W-1:0]   wr_port [1:NUM_REGS-1];

    always_comb begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            wdata[j] = wr_data[j*DATA_W +: DATA_W];
        end
    end

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_sel
        regfile_wr_select #(
            .NUM_WR (NUM_WR),
            .ADDR_W (ADDR_W)
        ) u_sel (
            .en     (wr_en),
            .addr   (wr_addr),
            .idx    (ADDR_W'(r)),
            .hit_c  (wr_hit[r]),
            .port_c (wr_port[r])
        );
    end

    // Writes retire producers; a same-cycle pend_set is applied last so a new producer wins.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (wr_hit[r]) begin
                regs_d[r] = wdata[wr_port[r]];
                pend_d[r] = 1'b0;
            end
        end
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (pend_set_en[j]) begin
                pend_d[pend_set_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        regs_d[0] = '0;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    logic [NUM_RD-1:0] byp_hit;
    logic [PORT_W-1:0] byp_port [NUM_RD];

    for (genvar i = 0; i < NUM_RD; i++) begin : g_byp
        regfile_wr_select #(
            .NUM_WR (NUM_WR),
            .ADDR_W (ADDR_W)
        ) u_byp (
            .en     (wr_en),
            .addr   (wr_addr),
            .idx    (rd_addr[i*ADDR_W +: ADDR_W]),
            .hit_c  (byp_hit[i]),
            .port_c (byp_port[i])
        );
    end
`endif

    // Combinational read; outputs held at zero while reset is asserted.
    always_comb begin
        rd_data    = '0;
        rd_pending = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            automatic logic [ADDR_W-1:0] ra = rd_addr[i*ADDR_W +: ADDR_W];
            rd_data[i*DATA_W +: DATA_W] = regs_q[ra];
            rd_pending[i]               = pend_q[ra];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (byp_hit[i] && (ra != ADDR_W'(REG_ZERO))) begin
                rd_data[i*DATA_W +: DATA_W] = wdata[byp_port[i]];
                rd_pending[i]               = 1'b0;
                for (int unsigned j = 0; j < NUM_WR; j++) begin
                    if (pend_set_en[j] && (pend_set_addr[j*ADDR_W +: ADDR_W] == ra)) begin
                        rd_pending[i] = 1'b1;
                    end
                end
            end
`endif
        end
        if (!reset) begin
            rd_data    = '0;
            rd_pending = '0;
        end
    end

endmodule

// File: tb/tb_mp_register_file.sv
// Directed checks of the default register file plus a randomised 6-read/3-write/64-bit instance.
module tb_mp_register_file;

    localparam int unsigned AW  = 5;
    localparam int unsigned DW  = 32;
    localparam int unsigned NRD = 4;
    localparam int unsigned NWR = 2;
    localparam int unsigned DW2  = 64;
    localparam int unsigned NRD2 = 6;
    localparam int unsigned NWR2 = 3;

    logic clk = 1'b0;
    logic reset;

    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_pending;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic [NWR-1:0]    pend_set_en;
    logic [NWR*AW-1:0] pend_set_addr;

    logic [NRD2*AW-1:0]  rd_addr2;
    logic [NRD2*DW2-1:0] rd_data2;
    logic [NRD2-1:0]     rd_pending2;
    logic [NWR2-1:0]     wr_en2;
    logic [NWR2*AW-1:0]  wr_addr2;
    logic [NWR2*DW2-1:0] wr_data2;
    logic [NWR2-1:0]     pend_set_en2;
    logic [NWR2*AW-1:0]  pend_set_addr2;

    logic [DW2-1:0] model [32];
    logic [DW-1:0]  exp_byp;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mp_register_file dut (
        .clk           (clk),
        .reset         (reset),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_pending    (rd_pending),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .pend_set_en   (pend_set_en),
        .pend_set_addr (pend_set_addr)
    );

    mp_register_file #(
        .DATA_W   (DW2),
        .NUM_REGS (32),
        .NUM_RD   (NRD2),
        .NUM_WR   (NWR2)
    ) dut2 (
        .clk           (clk),
        .reset         (reset),
        .rd_addr       (rd_addr2),
        .rd_data       (rd_data2),
        .rd_pending    (rd_pending2),
        .wr_en         (wr_en2),
        .wr_addr       (wr_addr2),
        .wr_data       (wr_data2),
        .pend_set_en   (pend_set_en2),
        .pend_set_addr (pend_set_addr2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en       = '0;
        pend_set_en = '0;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        rd_addr[i*AW +: AW] = a;
    endtask

    task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[j]             = 1'b1;
        wr_addr[j*AW +: AW]  = a;
        wr_data[j*DW +: DW]  = d;
    endtask

    task automatic set_pend(input int j, input logic [AW-1:0] a);
        pend_set_en[j]            = 1'b1;
        pend_set_addr[j*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rdv(input int i);
        return rd_data[i*DW +: DW];
    endfunction

    initial begin
        reset = 1'b0;
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        pend_set_en = '0; pend_set_addr = '0;
        rd_addr2 = '0; wr_en2 = '0; wr_addr2 = '0; wr_data2 = '0;
        pend_set_en2 = '0; pend_set_addr2 = '0;
        for (int r = 0; r < 32; r++) model[r] = '0;

        // Reset state
        set_rd(0, 5'd1); set_rd(1, 5'd2); set_rd(2, 5'd3); set_rd(3, 5'd31);
        #12;
        for (int i = 0; i < NRD; i++) chk($sformatf("rst_data%0d", i), 64'(rdv(i)), 64'h0);
        chk("rst_pend", 64'(rd_pending), 64'h0);
        reset = 1'b1;
        tick();

        // Async reset mid-cycle clears data and pending
        set_wr(0, 5'd5, 32'hDEADBEEF);
        set_pend(0, 5'd6);
        tick();
        idle();
        set_rd(0, 5'd5); set_rd(1, 5'd6);
        #1;
        chk("r5_written", 64'(rdv(0)), 64'hDEADBEEF);
        chk("r6_pending", 64'(rd_pending[1]), 64'h1);
        reset = 1'b0;
        #1;
        chk("async_rst_r5", 64'(rdv(0)), 64'h0);
        chk("async_rst_pend", 64'(rd_pending), 64'h0);
        #1;
        reset = 1'b1;
        tick();
        chk("r5_after_release", 64'(rdv(0)), 64'h0);
        chk("r6_pend_after_release", 64'(rd_pending[1]), 64'h0);

        // R0 protection
        set_wr(0, 5'd0, 32'hFFFFFFFF);
        set_wr(1, 5'd0, 32'hFFFFFFFF);
        set_pend(0, 5'd0); set_pend(1, 5'd0);
        for (int i = 0; i < NRD; i++) set_rd(i, 5'd0);
        #1;
        chk("r0_same_cycle", 64'(rdv(0)), 64'h0);
        tick();
        idle();
        #1;
        for (int i = 0; i < NRD; i++) chk($sformatf("r0_data%0d", i), 64'(rdv(i)), 64'h0);
        chk("r0_pend", 64'(rd_pending), 64'h0);

        // Write-write conflict: highest port wins
        set_wr(0, 5'd7, 32'h11);
        set_wr(1, 5'd7, 32'h22);
        tick();
        idle();
        set_rd(0, 5'd7);
        #1;
        chk("conflict_r7", 64'(rdv(0)), 64'h22);
        set_wr(0, 5'd3, 32'hA5);
        set_wr(1, 5'd4, 32'h5A);
        tick();
        idle();
        set_rd(1, 5'd3); set_rd(2, 5'd4);
        #1;
        chk("dual_r3", 64'(rdv(1)), 64'hA5);
        chk("dual_r4", 64'(rdv(2)), 64'h5A);
        chk("r7_still", 64'(rdv(0)), 64'h22);

        // Scoreboard set / clear / set-wins
        set_pend(1, 5'd9);
        tick();
        idle();
        set_rd(0, 5'd9);
        #1;
        chk("pend_set_r9", 64'(rd_pending[0]), 64'h1);
        set_wr(0, 5'd9, 32'h99);
        tick();
        idle();
        #1;
        chk("pend_clr_r9", 64'(rd_pending[0]), 64'h0);
        chk("data_r9", 64'(rdv(0)), 64'h99);
        set_wr(0, 5'd9, 32'h77);
        set_pend(1, 5'd9);
        tick();
        idle();
        #1;
        chk("pend_setwins_r9", 64'(rd_pending[0]), 64'h1);
        chk("data_r9_b", 64'(rdv(0)), 64'h77);

        // Read during write
        set_wr(0, 5'd12, 32'h0BAD);
        tick();
        idle();
        set_wr(0, 5'd12, 32'h1234);
        set_rd(0, 5'd12);
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        exp_byp = 32'h1234;
`else
        exp_byp = 32'h0BAD;
`endif
        chk("rdw_same_cycle", 64'(rdv(0)), 64'(exp_byp));
        chk("rdw_pend", 64'(rd_pending[0]), 64'h0);
        tick();
        idle();
        #1;
        chk("rdw_next_cycle", 64'(rdv(0)), 64'h1234);

        // Scaled instance against a reference model, with periodic 3-port collisions
        for (int it = 0; it < 40; it++) begin
            wr_en2 = '0;
            for (int p = 0; p < NRD2; p++) rd_addr2[p*AW +: AW] = AW'($urandom_range(0, 7));
            #1;
            for (int p = 0; p < NRD2; p++)
                chk($sformatf("scale_it%0d_p%0d", it, p), rd_data2[p*DW2 +: DW2],
                    model[rd_addr2[p*AW +: AW]]);
            for (int j = 0; j < NWR2; j++) begin
                wr_en2[j]               = 1'($urandom_range(0, 1));
                wr_addr2[j*AW +: AW]    = (it % 5 == 0) ? AW'(it % 8) : AW'($urandom_range(0, 7));
                wr_data2[j*DW2 +: DW2]  = {$urandom, $urandom};
            end
            if (it % 5 == 0) wr_en2 = '1;
            tick();
            for (int j = 0; j < NWR2; j++)
                if (wr_en2[j] && (wr_addr2[j*AW +: AW] != '0))
                    model[wr_addr2[j*AW +: AW]] = wr_data2[j*DW2 +: DW2];
        end
        wr_en2 = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mp_register_file.md
Name: mp_register_file

Overview:
- Parametrised successor to the dual-issue integer register file. It has N read ports, M write ports, and configurable data width and register count.
- Adds a per-register pending scoreboard so the issue stage can detect RAW hazards against in-flight producers.
- Sits between decode/issue (reads, pending-set) and writeback (writes, pending-clear) of the superscalar MIPS pipeline.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register in bits.
- NUM_REGS, 32, number of architectural registers; must be a power of 2 and at least 2.
- ADDR_W, $clog2(NUM_REGS), register address width; derived, not overridden.
- NUM_RD, 4, number of read ports.
- NUM_WR, 2, number of write ports; also the number of pending-set ports.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i is at [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way.
- rd_pending  out  NUM_RD  1 = register addressed by port i has an outstanding producer.
- wr_en  in  NUM_WR  write enable per port.
- wr_addr  in  NUM_WR*ADDR_W  write addresses.
- wr_data  in  NUM_WR*DATA_W  write data.
- pend_set_en  in  NUM_WR  issue marks destination as pending.
- pend_set_addr  in  NUM_WR*ADDR_W  destination addresses to mark.

Behaviour:
- Reset, reset low, asynchronous:
  - All NUM_REGS registers clear to 0.
  - All pending bits clear to 0.
  - While reset is held low: rd_data = 0 and rd_pending = 0 for every port.
  - Release is synchronous to the next rising edge of clk.
- Reads:
  - Combinational from the array; zero-cycle latency.
  - rd_addr = 0 always returns 0 with rd_pending = 0.
- Writes:
  - Take effect on the rising edge where wr_en[j]=1 and wr_addr[j]!=0.
  - Writes to address 0 are discarded.
- Write-write conflict: if several enabled ports target the same address in one cycle, the highest-index port wins and lower ports are dropped for that address. This generalises the existing rule that port 2 beats port 1.
- Pending scoreboard, one bit per register (bit 0 is constant 0):
  - Clear: an enabled write to addr a clears pend[a] at the edge.
  - Set: pend_set_en[j] with pend_set_addr[j]=a sets pend[a] at the edge; a=0 is ignored.
  - Set and clear on the same register in the same cycle: set wins, because a new producer supersedes the retiring one.
  - Multiple sets to the same register: idempotent.
- Read-during-write in the same cycle, without the optional feature: rd_data returns the old value; the new value is visible from the next cycle.
- rd_pending reflects the registered pend bit only; there is no combinational clear-forwarding unless the optional feature is enabled.
- Unknown or out-of-range addresses cannot occur, since NUM_REGS = 2^ADDR_W.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - A read whose address matches an enabled same-cycle write (non-zero address) returns that wr_data combinationally, using the highest-index matching port.
  - rd_pending for that port is forced to 0 unless a same-cycle pend_set targets the same address.
  - This replaces the old negedge write-then-read scheme.
- Undefined: no forwarding paths; behaviour as in the main description. This gives a smaller area and a shorter read path.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_W/NUM_REGS/NUM_RD/NUM_WR localparams;
  - the REG_ZERO constant (0);
  - the typedef for the packed address slice used by the issue stage.
- One sub-module, regfile_wr_select:
  - combinational, parametrised by NUM_WR and ADDR_W;
  - for a given register index, produces hit and the winning port index (highest-index priority);
  - instantiated per register via a generate loop and reused by the bypass logic.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse reset low mid-cycle (asynchronously) → r5 reads 0 immediately, and all rd_pending = 0.
- R0 protection: wr_en=2'b11 with both ports at addr 0, data 0xFFFFFFFF → rd_addr 0 reads 0 on every port; no pending bit is set by pend_set at addr 0.
- Write conflict: port0 writes r7=0x11, port1 writes r7=0x22 in the same cycle → next cycle r7 reads 0x22. Separately, port0 r3=0xA5 and port1 r4=0x5A → both are stored.
- Scoreboard: pend_set r9 → rd_pending=1 on the next cycle. Write r9 → pending=0 after the edge. Same-cycle write r9 plus pend_set r9 → pending stays 1.
- Bypass:
  - REGFILE_WRITE_BYPASS_EN defined: write r12=0x1234 while reading r12 in the same cycle → 0x1234 returned combinationally.
  - Macro undefined: the old value is returned, then 0x1234 on the next cycle.
- Port scaling: NUM_RD=6, NUM_WR=3, DATA_W=64 → random writes and reads check against a reference model, including three-port same-address collisions (port 2 wins).
